// File: rtl/y_cpu_pkg.sv
// Shared CPU front-end types and constants for the fetch path.
// The optional alignment check is selected by Y_FETCH_ALIGN_CHK_EN in y_fetch_q.
package y_cpu_pkg;

  localparam int ILEN     = 32;
  localparam int PC_STEP  = 4;
  localparam int XLEN_DEF = 32;

  typedef struct packed {
    logic [ILEN-1:0]     ins;
    logic [XLEN_DEF-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP,
    S_HALT
  } fetch_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/y_fifo.sv
// Synchronous power-of-two FIFO with clear; a pop frees room for a same-cycle push.
module y_fifo
  import y_cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop) && !clear;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/y_fetch_q.sv
// Instruction fetch unit: PC register, single-outstanding imem request FSM and prefetch queue.
// Define Y_FETCH_ALIGN_CHK_EN to halt on misaligned flush targets (adds fetch_misalign).
module y_fetch_q
  import y_cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            int_load,
  input  logic [XLEN-1:0] entry_point,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            ins_valid,
  output logic [31:0]     ins,
  output logic [XLEN-1:0] ins_pc,
  output logic [XLEN-1:0] ins_pcp4,
  input  logic            ins_ready
`ifdef Y_FETCH_ALIGN_CHK_EN
 ,output logic            fetch_misalign
`endif
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int EW    = ILEN + XLEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d, addr_q, addr_d, raw_tgt, tgt;
  logic            req_q, req_d;
  logic            flush, ack, pop, push, issue, halt_d;
  logic [CNT_W-1:0] fifo_count, cnt_after;
  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   head;

  assign flush   = int_load || redirect_valid;
  assign raw_tgt = int_load ? entry_point : redirect_pc;
  assign ack     = imem_ack && req_q;
  assign pop     = ins_valid && ins_ready;

`ifdef Y_FETCH_ALIGN_CHK_EN
  logic mis_q, mis_d;

  assign tgt            = raw_tgt;
  assign fetch_misalign = mis_q;

  // Only an aligned entry-point load releases a halt; redirects can only set it.
  always_comb begin
    mis_d = mis_q;
    if (int_load)                                   mis_d = (raw_tgt[1:0] != 2'b00);
    else if (redirect_valid && raw_tgt[1:0] != 2'b00) mis_d = 1'b1;
    halt_d = mis_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`else
  assign tgt    = raw_tgt & ~XLEN'(3);
  assign halt_d = 1'b0;
`endif

  // Request slot is reserved against the queue occupancy left after this cycle.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    issue   = 1'b0;
    if (flush) begin
      fpc_d = tgt;
    end else if (state_q == S_REQ && ack && (!fifo_full || pop)) begin
      push  = 1'b1;
      fpc_d = fpc_q + XLEN'(PC_STEP);
    end
    cnt_after = flush ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    unique case (state_q)
      S_REQ: begin
        if (ack)        issue   = 1'b1;
        else if (flush) state_d = S_DROP;
      end
      S_DROP:  if (ack) issue = 1'b1;
      default: issue = 1'b1;
    endcase
    if (issue) begin
      if (halt_d) begin
        state_d = S_HALT;
      end else if (cnt_after < CNT_W'(DEPTH)) begin
        state_d = S_REQ;
        addr_d  = fpc_d;
      end else begin
        state_d = S_IDLE;
      end
    end
    req_d = (state_d == S_REQ) || (state_d == S_DROP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  y_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .push     (push),
    .push_data({imem_rdata, fpc_q}),
    .pop      (pop),
    .pop_data (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ins_valid = !fifo_empty;
  assign ins       = head[EW-1:XLEN];
  assign ins_pc    = head[XLEN-1:0];
  assign ins_pcp4  = head[XLEN-1:0] + XLEN'(PC_STEP);

endmodule

// File: tb/tb_y_fetch_q.sv
// Directed self-checking bench for y_fetch_q; memory returns addr ^ KEY as instruction data.
module tb_y_fetch_q;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_load = 1'b0;
  logic [31:0] entry_point = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic [31:0] ins, ins_pc, ins_pcp4;
  logic        ins_ready = 1'b0;
  logic        auto_ack = 1'b0;
  logic        man_ack = 1'b0;
`ifdef Y_FETCH_ALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign imem_ack   = (auto_ack && imem_req) || man_ack;
  assign imem_rdata = imem_addr ^ KEY;

  y_fetch_q #(
    .XLEN(32),
    .DEPTH(4),
    .RESET_PC(32'h28)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .int_load      (int_load),
    .entry_point   (entry_point),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ins_valid     (ins_valid),
    .ins           (ins),
    .ins_pc        (ins_pc),
    .ins_pcp4      (ins_pcp4),
    .ins_ready     (ins_ready)
`ifdef Y_FETCH_ALIGN_CHK_EN
   ,.fetch_misalign(fetch_misalign)
`endif
  );

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    int_load = 1'b0;
    redirect_valid = 1'b0;
    auto_ack = 1'b0;
    man_ack = 1'b0;
    ins_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    tests_run++;
    if (ins_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", ins_valid); end
    tests_run++;
    if (imem_addr !== 32'h28) begin tests_failed++; $display("[TB] FAIL reset_addr: got %h expected 00000028", imem_addr); end
`ifdef Y_FETCH_ALIGN_CHK_EN
    tests_run++;
    if (fetch_misalign !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_misalign: got %b expected 0", fetch_misalign); end
`endif
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    auto_ack = 1'b1;
    ins_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (imem_addr !== 32'h28 + 32'(4 * i)) begin
        tests_failed++; $display("[TB] FAIL stream_addr%0d: got %h expected %h", i, imem_addr, 32'h28 + 32'(4 * i));
      end
      if (i > 0) begin
        exp_pc = 32'h28 + 32'(4 * (i - 1));
        tests_run++;
        if (ins_valid !== 1'b1 || ins_pc !== exp_pc || ins_pcp4 !== exp_pc + 32'd4 || ins !== (exp_pc ^ KEY)) begin
          tests_failed++;
          $display("[TB] FAIL stream_head%0d: got v=%b pc=%h pcp4=%h ins=%h expected pc=%h", i, ins_valid, ins_pc, ins_pcp4, ins, exp_pc);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acks = 0;
    logic [31:0] got [5];
    int n = 0;
    do_reset();
    auto_ack = 1'b1;
    ins_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req && imem_ack) acks++;
    end
    tests_run++;
    if (acks != 4) begin tests_failed++; $display("[TB] FAIL bp_pushes: got %0d expected 4", acks); end
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_req_stop: got %b expected 0", imem_req); end
    ins_ready = 1'b1;
    for (int i = 0; i < 12 && n < 5; i++) begin
      if (ins_valid) begin got[n] = ins_pc; n++; end
      @(negedge clk);
    end
    tests_run++;
    if (n != 5) begin tests_failed++; $display("[TB] FAIL bp_drain_count: got %0d expected 5", n); end
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got[i] !== 32'h28 + 32'(4 * i)) begin
        tests_failed++; $display("[TB] FAIL bp_order%0d: got %h expected %h", i, got[i], 32'h28 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    int_load = 1'b1;
    entry_point = 32'h40;
    ins_ready = 1'b1;
    @(negedge clk);
    int_load = 1'b0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      tests_failed++; $display("[TB] FAIL rdi_req40: got req=%b addr=%h expected req=1 addr=00000040", imem_req, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      tests_failed++; $display("[TB] FAIL rdi_hold: got req=%b addr=%h expected req=1 addr=00000040", imem_req, imem_addr);
    end
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    tests_run++;
    if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      tests_failed++; $display("[TB] FAIL rdi_drop: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000100", ins_valid, imem_req, imem_addr);
    end
    auto_ack = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h100 || ins !== (32'h100 ^ KEY)) begin
      tests_failed++; $display("[TB] FAIL rdi_first: got v=%b pc=%h ins=%h expected pc=00000100", ins_valid, ins_pc, ins);
    end
  endtask

  task automatic test_redirect_same_ack();
    do_reset();
    auto_ack = 1'b1;
    ins_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ins_valid !== 1'b1 || imem_ack !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL rsa_pre: got v=%b ack=%b expected both 1", ins_valid, imem_ack);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      tests_failed++; $display("[TB] FAIL rsa_flush: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000200", ins_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h200 || ins !== (32'h200 ^ KEY)) begin
      tests_failed++; $display("[TB] FAIL rsa_first: got v=%b pc=%h ins=%h expected pc=00000200", ins_valid, ins_pc, ins);
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    auto_ack = 1'b1;
    ins_ready = 1'b1;
    repeat (3) @(negedge clk);
    int_load = 1'b1;
    entry_point = 32'h44;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    int_load = 1'b0;
    redirect_valid = 1'b0;
    tests_run++;
    if (ins_valid !== 1'b0 || imem_addr !== 32'h44) begin
      tests_failed++; $display("[TB] FAIL prio_addr: got v=%b addr=%h expected v=0 addr=00000044", ins_valid, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h44) begin
      tests_failed++; $display("[TB] FAIL prio_pc: got v=%b pc=%h expected pc=00000044", ins_valid, ins_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    int_load = 1'b1;
    entry_point = 32'hFFFF_FFFC;
    auto_ack = 1'b1;
    ins_ready = 1'b1;
    @(negedge clk);
    int_load = 1'b0;
    tests_run++;
    if (imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL wrap_addr0: got %h expected fffffffc", imem_addr); end
    @(negedge clk);
    tests_run++;
    if (ins_pc !== 32'hFFFF_FFFC || ins_pcp4 !== 32'h0 || imem_addr !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL wrap: got pc=%h pcp4=%h addr=%h expected fffffffc/0/0", ins_pc, ins_pcp4, imem_addr);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    auto_ack = 1'b1;
    ins_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    auto_ack = 1'b0;
    man_ack = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || ins_valid !== 1'b0 || imem_addr !== 32'h28) begin
      tests_failed++; $display("[TB] FAIL midreset: got req=%b v=%b addr=%h expected 0/0/00000028", imem_req, ins_valid, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    tests_run++;
    if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h28) begin
      tests_failed++; $display("[TB] FAIL stray_ack: got v=%b req=%b addr=%h expected 0/1/00000028", ins_valid, imem_req, imem_addr);
    end
  endtask

`ifdef Y_FETCH_ALIGN_CHK_EN
  task automatic test_align();
    do_reset();
    auto_ack = 1'b1;
    ins_ready = 1'b1;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || ins_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL align_set: got mis=%b req=%b v=%b expected 1/0/0", fetch_misalign, imem_req, ins_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (fetch_misalign !== 1'b1 || imem_req !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL align_sticky: got mis=%b req=%b expected 1/0", fetch_misalign, imem_req);
    end
    int_load = 1'b1;
    entry_point = 32'h0;
    @(negedge clk);
    int_load = 1'b0;
    tests_run++;
    if (fetch_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL align_clear: got mis=%b req=%b addr=%h expected 0/1/0", fetch_misalign, imem_req, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL align_resume: got v=%b pc=%h expected 1/0", ins_valid, ins_pc);
    end
  endtask
`else
  task automatic test_align();
    do_reset();
    auto_ack = 1'b1;
    ins_ready = 1'b1;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      tests_failed++; $display("[TB] FAIL align_force: got req=%b addr=%h expected 1/00000100", imem_req, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h100) begin
      tests_failed++; $display("[TB] FAIL align_force_pc: got v=%b pc=%h expected 1/00000100", ins_valid, ins_pc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_ack();
    test_load_priority();
    test_wrap();
    test_reset_midflight();
    test_align();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/y_fetch_q.md
# y_fetch_q

Parametrised instruction-fetch unit with prefetch queue. It is the successor to the single-cycle PC/IF pair. It owns the PC register and issues requests to instruction memory over a req/ack handshake, buffering returned instructions in a DEPTH-entry queue. It delivers {ins, pc, pc+4} to decode over a valid/ready handshake, and flushes on entry-point load or branch/jump redirect.

## Interface
Parameters:
- XLEN, 32, PC/address width
- DEPTH, 4, queue entries; power of 2, ≥2
- RESET_PC, 0, PC loaded by reset

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- int_load  in  1  load entry_point; flush everything
- entry_point  in  XLEN  entry address for int_load
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  XLEN  redirect target
- imem_req  out  1  fetch request (registered)
- imem_addr  out  XLEN  fetch address; stable while imem_req && !imem_ack
- imem_ack  in  1  response valid; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- ins_valid  out  1  queue head valid
- ins  out  32  head instruction
- ins_pc  out  XLEN  head PC
- ins_pcp4  out  XLEN  head PC+4
- ins_ready  in  1  decode accepts head
- fetch_misalign  out  1  sticky misaligned-target flag (Y_FETCH_ALIGN_CHK_EN only)

## Operation
- Reset values:
  - fpc = RESET_PC; queue empty
  - imem_req = 0, ins_valid = 0, drop = 0, fetch_misalign = 0
  - imem_addr = RESET_PC
- At most one outstanding request. A request is "in flight" from the imem_req rise until the imem_ack cycle.
- Request rule: assert imem_req next cycle iff (count + inflight_after_this_cycle) < DEPTH and not halted. Once asserted, imem_req and imem_addr hold until ack.
- Normal ack: push {imem_rdata, fpc} and set fpc += 4 (mod 2^XLEN, wrap silent).
- Pop: ins_valid && ins_ready removes the head. Push and pop in the same cycle are both honoured, including when full.
- Flush priority: int_load > redirect_valid > normal.
- On flush:
  - queue cleared
  - fpc = entry_point / redirect_pc
  - if a request is in flight and not acked this cycle, set drop
  - a same-cycle ack is discarded
  - a same-cycle pop counts as accepted
- drop: the next ack is discarded and clears drop. A new request to the new fpc issues the cycle after that ack. With no request in flight, the new request issues the cycle after the flush.
- Redirect while drop already set: fpc is updated; drop stays set (the single outstanding response is still discarded).
- Reset mid-transaction: all state returns to reset values at once. A later stray ack while imem_req=0 is ignored.

## Timing
- Flush at cycle N → imem_req=1 with new addr at N+1 (no in-flight request).
- Ack at N into an empty queue → ins_valid=1 at N+1 (registered head).
- With imem_ack every cycle and ins_ready=1, sustained throughput is 1 instruction/cycle.
- ins_valid falls the cycle after a flush.
- Outputs have no combinational path from ins_ready or imem_ack.

## Configuration
- Y_FETCH_ALIGN_CHK_EN defined:
  - a flush target with addr[1:0]≠0 sets fetch_misalign
  - fetch halts: imem_req stays 0 and the queue is empty
  - only int_load with an aligned entry_point or reset clears it
- Y_FETCH_ALIGN_CHK_EN undefined:
  - target low bits are forced to 0
  - fetch_misalign port is absent

## Structure
- Shared package y_cpu_pkg:
  - ILEN=32, PC_STEP=4
  - fetch_entry_t struct {ins, pc}
  - CNT_W = $clog2(DEPTH)+1
- Sub-module y_fifo: parametrised synchronous FIFO (width, depth, push/pop/clear, count, full/empty).
- y_fetch_q holds the PC register, request FSM (IDLE, REQ, DROP, HALT) and flush logic.

## Test plan
- Reset RESET_PC=0x28, ack every cycle, ins_ready=1 → imem_addr sequence 0x28, 0x2C, 0x30; ins_pc follows one cycle after each ack; ins_pcp4 = ins_pc+4.
- ins_ready=0, DEPTH=4, ack immediate → exactly 4 pushes then imem_req=0. Raising ins_ready drains 0x28..0x34 in order and resumes at 0x38.
- redirect_valid with redirect_pc=0x100 while a request to 0x40 is in flight, ack 3 cycles later → that response dropped, queue empty; next req addr=0x100; first ins_pc=0x100.
- Same-cycle redirect (0x200) and ack → ack data discarded; imem_req at 0x200 next cycle.
- int_load with entry_point=0x44 concurrent with redirect_pc=0x80 → fetch resumes at 0x44.
- Y_FETCH_ALIGN_CHK_EN, redirect_pc=0x102 → fetch_misalign=1, imem_req stays 0. int_load 0x0 clears the flag; fetch resumes at 0x0.
